// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for a weight-stationary systolic PE grid: preload, bank swap, compute, drain.
// Optional perf counters (perf_stall, perf_busy) are built when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_array_ctrl #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             cfg_opsel,
    input  logic [CNT_W-1:0] cfg_tiles,
    input  logic [CNT_W-1:0] cfg_vecs,
    output logic             busy,
    output logic             done,
    output logic             w_rd,
    input  logic             w_valid,
    output logic             a_rd,
    input  logic             a_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pe_en,
    output logic             pe_selector,
    output logic             pe_opsel,
    output logic             pe_w_en,
    output logic [CNT_W-1:0] tile_idx
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_busy
`endif
);

    localparam int unsigned LAT  = ROWS + COLS - 1;
    localparam int unsigned PH_W = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_SWAP    = 3'd2,
        S_COMPUTE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              opsel_q, opsel_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  tiles_q, tiles_d;
    logic [CNT_W-1:0]  vecs_q, vecs_d;
    logic [CNT_W-1:0]  tile_idx_q, tile_idx_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [LAT-1:0]    pipe_q, pipe_d;

    logic              active;
    logic              more_tiles;
    logic              a_rd_need;
    logic              w_rd_need;
    logic              pipe_out;
    logic              stall;
    logic              start_acc;
    logic [PH_W-1:0]   issue_len;
    logic [PH_W-1:0]   compute_last;

    // Read requests, stall and grid enable; all combinational on the current phase.
    always_comb begin
        active     = (state_q == S_PRELOAD) || (state_q == S_COMPUTE);
        more_tiles = (tile_idx_q != (tiles_q - CNT_W'(1)));
        issue_len  = PH_W'(vecs_q);
        if (more_tiles && (PH_W'(vecs_q) < PH_W'(ROWS))) begin
            issue_len = PH_W'(ROWS);
        end
        compute_last = issue_len + PH_W'(LAT - 1);
        a_rd_need    = (state_q == S_COMPUTE) && (ph_cnt_q < PH_W'(vecs_q));
        w_rd_need    = (state_q == S_PRELOAD) ||
                       ((state_q == S_COMPUTE) && more_tiles && (ph_cnt_q < PH_W'(ROWS)));
        pipe_out     = pipe_q[LAT-1];
        stall        = (a_rd_need & ~a_valid) | (w_rd_need & ~w_valid) | (pipe_out & ~out_ready);
        pe_en        = active & ~stall;
        w_rd         = w_rd_need & pe_en;
        a_rd         = a_rd_need & pe_en;
        pe_w_en      = w_rd;
        out_valid    = pipe_out & pe_en;
        start_acc    = (state_q == S_IDLE) && start;
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign pe_selector = sel_q;
    assign pe_opsel    = busy & opsel_q;
    assign tile_idx    = tile_idx_q;

    // Next-state logic; every counter and the latency pipe hold unless pe_en.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        opsel_d    = opsel_q;
        first_d    = first_q;
        tiles_d    = tiles_q;
        vecs_d     = vecs_q;
        tile_idx_d = tile_idx_q;
        ph_cnt_d   = ph_cnt_q;
        pipe_d     = pipe_q;
        if (pe_en) begin
            pipe_d = LAT'({pipe_q, a_rd});
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opsel_d    = cfg_opsel;
                    tiles_d    = cfg_tiles;
                    vecs_d     = cfg_vecs;
                    tile_idx_d = '0;
                    first_d    = 1'b1;
                    ph_cnt_d   = '0;
                    pipe_d     = '0;
                    if ((cfg_tiles == '0) || (cfg_vecs == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PRELOAD;
                    end
                end
            end
            S_PRELOAD: begin
                if (pe_en) begin
                    if (ph_cnt_q == PH_W'(ROWS - 1)) begin
                        ph_cnt_d = '0;
                        state_d  = S_SWAP;
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
            end
            S_SWAP: begin
                sel_d    = ~sel_q;
                first_d  = 1'b0;
                ph_cnt_d = '0;
                state_d  = S_COMPUTE;
                if (!first_q) begin
                    tile_idx_d = tile_idx_q + CNT_W'(1);
                end
            end
            S_COMPUTE: begin
                // Issue then drain LAT cycles so no sum is in flight across a swap.
                if (pe_en) begin
                    if (ph_cnt_q == compute_last) begin
                        ph_cnt_d = '0;
                        state_d  = more_tiles ? S_SWAP : S_DONE;
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            opsel_q    <= 1'b0;
            first_q    <= 1'b0;
            tiles_q    <= '0;
            vecs_q     <= '0;
            tile_idx_q <= '0;
            ph_cnt_q   <= '0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            opsel_q    <= opsel_d;
            first_q    <= first_d;
            tiles_q    <= tiles_d;
            vecs_q     <= vecs_d;
            tile_idx_q <= tile_idx_d;
            ph_cnt_q   <= ph_cnt_d;
            pipe_q     <= pipe_d;
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    // Saturating stall/busy cycle counters, cleared by an accepted start.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_busy_d  = perf_busy_q;
        if (start_acc) begin
            perf_stall_d = '0;
            perf_busy_d  = '0;
        end else begin
            if (active && stall && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
            if (busy && (perf_busy_q != '1)) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            perf_stall_q <= '0;
            perf_busy_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_busy_q  <= perf_busy_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_busy  = perf_busy_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: slot-schedule reference model, table-driven jobs, reset/abort sequence.
module tb_systolic_array_ctrl;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned CNT_W = 16;
    localparam int          LAT   = ROWS + COLS - 1;

    logic             CLK;
    logic             RESET;
    logic             start;
    logic             cfg_opsel;
    logic [CNT_W-1:0] cfg_tiles;
    logic [CNT_W-1:0] cfg_vecs;
    logic             busy;
    logic             done;
    logic             w_rd;
    logic             w_valid;
    logic             a_rd;
    logic             a_valid;
    logic             out_valid;
    logic             out_ready;
    logic             pe_en;
    logic             pe_selector;
    logic             pe_opsel;
    logic             pe_w_en;
    logic [CNT_W-1:0] tile_idx;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]      perf_stall;
    logic [31:0]      perf_busy;
`endif

    systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .start       (start),
        .cfg_opsel   (cfg_opsel),
        .cfg_tiles   (cfg_tiles),
        .cfg_vecs    (cfg_vecs),
        .busy        (busy),
        .done        (done),
        .w_rd        (w_rd),
        .w_valid     (w_valid),
        .a_rd        (a_rd),
        .a_valid     (a_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pe_en       (pe_en),
        .pe_selector (pe_selector),
        .pe_opsel    (pe_opsel),
        .pe_w_en     (pe_w_en),
        .tile_idx    (tile_idx)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_stall  (perf_stall),
        .perf_busy   (perf_busy)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One schedule slot: an enabled grid cycle, a bank swap, or the done cycle.
    typedef struct {
        int   kind;   // 0 enabled, 1 swap, 2 done
        logic w;
        logic a;
        logic o;
        int   tile;
    } slot_t;

    typedef struct {
        int   tiles;
        int   vecs;
        logic opsel;
        int   mode;      // 0 all ready, 1 random, 2 a_valid gap, 3 out_ready gap
        int   exp_done;  // -1 when timing depends on random stalls
        int   exp_outs;
    } job_t;

    int   n_vec;
    int   n_bad;
    logic model_sel;

    task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic b, input logic d, input logic w, input logic a,
                                         input logic o, input logic en, input logic op,
                                         input logic sel, input logic [15:0] tile);
        return {7'd0, b, d, w, a, o, en, w, op, sel, tile};
    endfunction

    task automatic run_job(input int tiles, input int vecs, input logic op, input int mode,
                           output int done_cyc, output int outs);
        slot_t       q[$];
        slot_t       s;
        int          cyc;
        int          budget;
        int          issue;
        bit          more;
        bit          stalled;
        logic [31:0] got;
        logic [31:0] exp;
        logic        dsel;
        logic [15:0] dtile;

        // Build the expected schedule from the tile/vector arithmetic.
        if (tiles == 0 || vecs == 0) begin
            q.push_back('{2, 1'b0, 1'b0, 1'b0, 0});
        end else begin
            for (int t = 0; t < tiles; t++) begin
                if (t == 0) begin
                    for (int r = 0; r < int'(ROWS); r++) q.push_back('{0, 1'b1, 1'b0, 1'b0, 0});
                end
                q.push_back('{1, 1'b0, 1'b0, 1'b0, t});
                more  = (t < tiles - 1);
                issue = (more && vecs < int'(ROWS)) ? int'(ROWS) : vecs;
                for (int i = 0; i < issue + LAT; i++) begin
                    q.push_back('{0, more && i < int'(ROWS), i < vecs, (i >= LAT) && (i < vecs + LAT), t});
                end
            end
            q.push_back('{2, 1'b0, 1'b0, 1'b0, tiles - 1});
        end
        budget   = q.size() * 12 + 50;
        done_cyc = -1;
        outs     = 0;

        start     = 1'b1;
        cfg_tiles = CNT_W'(tiles);
        cfg_vecs  = CNT_W'(vecs);
        cfg_opsel = op;
        w_valid   = 1'b1;
        a_valid   = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        check("idle_at_start", 0, pack(busy, done, w_rd, a_rd, out_valid, pe_en, pe_opsel, pe_selector, 16'd0),
              pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_sel, 16'd0));
        @(posedge CLK);
        #1;
        start = 1'b0;
        cyc   = 1;

        while (q.size() > 0 && cyc < budget) begin
            w_valid   = 1'b1;
            a_valid   = 1'b1;
            out_ready = 1'b1;
            start     = 1'b0;
            if (mode == 1) begin
                w_valid   = ($urandom_range(0, 3) != 0);
                a_valid   = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 15) == 0);
                cfg_tiles = CNT_W'($urandom_range(0, 5));
                cfg_vecs  = CNT_W'($urandom_range(0, 9));
                cfg_opsel = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                a_valid = !(cyc >= 7 && cyc <= 9);
            end else if (mode == 3) begin
                out_ready = !(cyc == 13 || cyc == 14);
            end
            @(negedge CLK);
            s = q[0];
            if (s.kind == 1) begin
                exp  = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b0, 16'd0);
                dsel = 1'b0;
                dtile = 16'd0;
                void'(q.pop_front());
                model_sel = ~model_sel;
            end else if (s.kind == 2) begin
                exp   = pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op, model_sel, 16'(s.tile));
                dsel  = pe_selector;
                dtile = tile_idx;
                void'(q.pop_front());
                done_cyc = cyc;
            end else begin
                stalled = (s.w && !w_valid) || (s.a && !a_valid) || (s.o && !out_ready);
                dsel  = pe_selector;
                dtile = tile_idx;
                if (stalled) begin
                    exp = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, model_sel, 16'(s.tile));
                end else begin
                    exp = pack(1'b1, 1'b0, s.w, s.a, s.o, 1'b1, op, model_sel, 16'(s.tile));
                    void'(q.pop_front());
                end
            end
            got = pack(busy, done, w_rd, a_rd, out_valid, pe_en, pe_opsel, dsel, dtile);
            if (pe_w_en !== w_rd) got[30] = 1'b1;
            check("cycle", cyc, got, exp);
            if (out_valid === 1'b1) outs++;
            @(posedge CLK);
            #1;
            cyc++;
        end
        if (q.size() != 0) begin
            check("timeout", cyc, 32'(q.size()), 32'd0);
        end

        start     = 1'b0;
        w_valid   = 1'b1;
        a_valid   = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        check("idle_after", cyc, pack(busy, done, w_rd, a_rd, out_valid, pe_en, pe_opsel, pe_selector, 16'd0),
              pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_sel, 16'd0));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        job_t jobs[$];
        int   dc;
        int   oc;

        n_vec     = 0;
        n_bad     = 0;
        model_sel = 1'b0;
        RESET     = 1'b1;
        start     = 1'b0;
        cfg_opsel = 1'b0;
        cfg_tiles = '0;
        cfg_vecs  = '0;
        w_valid   = 1'b0;
        a_valid   = 1'b0;
        out_ready = 1'b0;

        jobs.push_back('{1, 5, 1'b1, 0, 18, 5});
        jobs.push_back('{3, 2, 1'b0, 0, 39, 6});
        jobs.push_back('{1, 5, 1'b1, 2, 21, 5});
        jobs.push_back('{1, 5, 1'b0, 3, 20, 5});
        jobs.push_back('{0, 3, 1'b1, 0, 1, 0});
        jobs.push_back('{2, 0, 1'b1, 0, 1, 0});
        jobs.push_back('{2, 6, 1'b1, 0, 33, 12});
        jobs.push_back('{1, 1, 1'b0, 0, 14, 1});
        jobs.push_back('{2, 3, 1'b1, 0, 28, 6});
        jobs.push_back('{3, 4, 1'b1, 1, -1, 12});
        jobs.push_back('{2, 7, 1'b0, 1, -1, 14});
        jobs.push_back('{4, 1, 1'b1, 1, -1, 4});
        jobs.push_back('{1, 9, 1'b0, 1, -1, 9});

        #2;
        check("reset_outputs", 0, {busy, done, w_rd, a_rd, out_valid, pe_en, pe_selector, pe_opsel, pe_w_en, tile_idx},
              32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        for (int j = 0; j < jobs.size(); j++) begin
            run_job(jobs[j].tiles, jobs[j].vecs, jobs[j].opsel, jobs[j].mode, dc, oc);
            check("out_count", j, 32'(oc), 32'(jobs[j].exp_outs));
            if (jobs[j].exp_done >= 0) begin
                check("done_cycle", j, 32'(dc), 32'(jobs[j].exp_done));
            end
`ifdef SYSTOLIC_CTRL_PERF_EN
            if (jobs[j].mode == 2) begin
                check("perf_stall", j, perf_stall, 32'd3);
                check("perf_busy", j, perf_busy, 32'd21);
            end
`endif
        end

        // Abort a job mid-compute with an asynchronous reset, then run a fresh job.
        start     = 1'b1;
        cfg_tiles = CNT_W'(2);
        cfg_vecs  = CNT_W'(3);
        cfg_opsel = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        check("mid_compute", 8, {29'd0, busy, pe_en, pe_selector}, {29'd0, 1'b1, 1'b1, ~model_sel});
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset", 8, {busy, done, w_rd, a_rd, out_valid, pe_en, pe_selector, pe_opsel, pe_w_en, tile_idx},
              32'd0);
        @(posedge CLK);
        #1;
        RESET     = 1'b0;
        model_sel = 1'b0;
        run_job(1, 5, 1'b1, 0, dc, oc);
        check("post_reset_done", 0, 32'(dc), 32'd18);
        check("post_reset_outs", 0, 32'(oc), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
